simple_rx_checker: RTL

//  AXI4-Stream sink and checker. Pairs with the simple packet generator as the receive end of the loopback path.

---
 rtl/simple_pkt_pkg.sv | 30 +++
 rtl/simple_stat_counter.sv | 40 ++++
 rtl/simple_rx_checker.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/simple_pkt_pkg.sv
// Shared definitions for the simple packet generator / receive checker pair.
//  - FSM state encoding of the receive checker (exported on its debug port)
//  - error-code bit positions reported in last_err
//  - default header / payload patterns, identical to the generator's
//  - helper: 16-bit saturating increment for the beat counter
package simple_pkt_pkg;

  // Receive FSM states
  localparam logic [0:0] ST_WAIT_HDR = 1'b0;
  localparam logic [0:0] ST_PAYLOAD  = 1'b1;

  // Error code layout (5 bits)
  localparam int ERR_W    = 5;
  localparam int ERR_HDR  = 0;  // first beat tdata != header pattern
  localparam int ERR_PAY  = 1;  // later beat tdata != payload pattern
  localparam int ERR_CNT  = 2;  // beat count != expected packet size
  localparam int ERR_LEN  = 3;  // tuser length field != beats * bytes per beat
  localparam int ERR_STRB = 4;  // some beat had a partial tstrb

  // Patterns the generator emits
  localparam logic [63:0] DEF_HDR_PATTERN     = 64'haaaaaaaaaaaaaaaa;
  localparam logic [63:0] DEF_PAYLOAD_PATTERN = 64'hffffffffffffffff;

  // Beat counter sticks at all-ones so over-long packets never alias
  // back onto a legal size.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/simple_stat_counter.sv
// 32-bit statistics counter.
//  - inc_i adds one per cycle, wrapping 0xFFFFFFFF -> 0
//  - clr_i zeroes the counter and wins over a same-cycle increment
// Ports:
//  clk_i    clock
//  rst_ni   asynchronous active-low reset
//  clr_i    synchronous clear
//  inc_i    increment enable
//  count_o  current count
module simple_stat_counter (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clr_i,
  input  logic        inc_i,
  output logic [31:0] count_o
);

  logic [31:0] count_q;
  logic [31:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = 32'd0;
    end else if (inc_i) begin
      count_d = count_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= 32'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/simple_rx_checker.sv
// AXI4-Stream sink that checks every packet against the fixed generator
// format (header word, payload words, beat count, optional tuser length,
// full strobes) and keeps packet / error / word statistics.
//
// Handshake: s_axis_tready is tied high, so a beat is transferred on every
// rising edge where s_axis_tvalid is 1; a cycle with tvalid=0 changes
// nothing in the packet tracking.
//
// Ports:
//  axi_aclk, axi_aresetn     clock, asynchronous active-low reset
//  s_axis_tdata/tstrb/tuser  stream payload, strobes, sideband (tuser[15:0]
//                            = byte length, sampled on the first beat only)
//  s_axis_tvalid/tready/tlast stream control
//  rst_cntrs                 synchronous clear of counters and last_err
//  rx_count/err_count/word_count  packet, bad-packet and beat counters
//  last_err                  error code of the most recent completed packet
//  pkt_done/pkt_err          one-cycle pulses after each completed packet
//  dbg_state                 current FSM state (ST_WAIT_HDR / ST_PAYLOAD)
module simple_rx_checker
  import simple_pkt_pkg::*;
#(
  parameter int                         C_S_AXIS_DATA_WIDTH  = 64,
  parameter int                         C_S_AXIS_TUSER_WIDTH = 128,
  parameter int                         C_CHECK_PKT_SIZE     = 2,
  parameter logic [C_S_AXIS_DATA_WIDTH-1:0] C_HDR_PATTERN     = DEF_HDR_PATTERN,
  parameter logic [C_S_AXIS_DATA_WIDTH-1:0] C_PAYLOAD_PATTERN = DEF_PAYLOAD_PATTERN,
  parameter int                         C_CHECK_LEN          = 0
) (
  input  logic                              axi_aclk,
  input  logic                              axi_aresetn,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic                              s_axis_tvalid,
  output logic                              s_axis_tready,
  input  logic                              s_axis_tlast,
  input  logic                              rst_cntrs,
  output logic [31:0]                       rx_count,
  output logic [31:0]                       err_count,
  output logic [31:0]                       word_count,
  output logic [ERR_W-1:0]                  last_err,
  output logic                              pkt_done,
  output logic                              pkt_err,
  output logic [0:0]                        dbg_state
);

  localparam int BYTES_PER_BEAT = C_S_AXIS_DATA_WIDTH / 8;

  logic [0:0]       state_q,    state_d;
  logic [15:0]      beats_q,    beats_d;
  logic [ERR_W-1:0] err_q,      err_d;
  logic [15:0]      len_q,      len_d;
  logic [ERR_W-1:0] last_err_q, last_err_d;
  logic             pkt_done_q, pkt_err_q;

  // Values as they stand including the beat currently presented
  logic [15:0]      beats_cur;
  logic [ERR_W-1:0] err_cur;
  logic [15:0]      len_cur;
  logic [ERR_W-1:0] code;
  logic [19:0]      exp_len;

  logic beat;
  logic done;

  assign beat = s_axis_tvalid;
  assign done = beat && s_axis_tlast;

  // Only the length field of tuser is meaningful here
  logic unused_tuser;
  assign unused_tuser = ^s_axis_tuser[C_S_AXIS_TUSER_WIDTH-1:16];

  always_comb begin
    beats_cur = beats_q;
    err_cur   = err_q;
    len_cur   = len_q;

    if (state_q == ST_WAIT_HDR) begin
      beats_cur = 16'd1;
      len_cur   = s_axis_tuser[15:0];
      if (s_axis_tdata != C_HDR_PATTERN) err_cur[ERR_HDR] = 1'b1;
    end else begin
      beats_cur = sat_inc16(beats_q);
      if (s_axis_tdata != C_PAYLOAD_PATTERN) err_cur[ERR_PAY] = 1'b1;
    end

    if (s_axis_tstrb != '1) err_cur[ERR_STRB] = 1'b1;

    // Completion checks; only meaningful when the beat carries tlast
    exp_len = {4'd0, beats_cur} * 20'(BYTES_PER_BEAT);
    code    = err_cur;
    if ((beats_cur == 16'hFFFF) || (beats_cur != 16'(C_CHECK_PKT_SIZE))) begin
      code[ERR_CNT] = 1'b1;
    end
    if ((C_CHECK_LEN != 0) && ({4'd0, len_cur} != exp_len)) begin
      code[ERR_LEN] = 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    beats_d    = beats_q;
    err_d      = err_q;
    len_d      = len_q;
    last_err_d = last_err_q;

    if (done) begin
      state_d = ST_WAIT_HDR;
      beats_d = 16'd0;
      err_d   = '0;
      len_d   = 16'd0;
    end else if (beat) begin
      state_d = ST_PAYLOAD;
      beats_d = beats_cur;
      err_d   = err_cur;
      len_d   = len_cur;
    end

    // Clearing statistics drops a packet completing in the same cycle
    if (rst_cntrs) begin
      last_err_d = '0;
    end else if (done) begin
      last_err_d = code;
    end
  end

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      state_q    <= ST_WAIT_HDR;
      beats_q    <= 16'd0;
      err_q      <= '0;
      len_q      <= 16'd0;
      last_err_q <= '0;
      pkt_done_q <= 1'b0;
      pkt_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      beats_q    <= beats_d;
      err_q      <= err_d;
      len_q      <= len_d;
      last_err_q <= last_err_d;
      pkt_done_q <= done;
      pkt_err_q  <= done && (code != '0);
    end
  end

  simple_stat_counter u_rx_cnt (
    .clk_i   (axi_aclk),
    .rst_ni  (axi_aresetn),
    .clr_i   (rst_cntrs),
    .inc_i   (done),
    .count_o (rx_count)
  );

  simple_stat_counter u_err_cnt (
    .clk_i   (axi_aclk),
    .rst_ni  (axi_aresetn),
    .clr_i   (rst_cntrs),
    .inc_i   (done && (code != '0)),
    .count_o (err_count)
  );

  simple_stat_counter u_word_cnt (
    .clk_i   (axi_aclk),
    .rst_ni  (axi_aresetn),
    .clr_i   (rst_cntrs),
    .inc_i   (beat),
    .count_o (word_count)
  );

  assign s_axis_tready = 1'b1;
  assign last_err      = last_err_q;
  assign pkt_done      = pkt_done_q;
  assign pkt_err       = pkt_err_q;
  assign dbg_state     = state_q;

endmodule
